bus_reg_bank: RTL and testbench
===============================

# bus_reg_bank

Parametrised bank of NUM_REGS general-purpose registers, each WIDTH bits, attached to the shared tri-state system bus of the 8-bit computer. It replaces single fixed-width bus registers with one block that supports the following per cycle:
- indexed load from the bus;
- indexed drive onto the bus;
- per-register clear;
- an increment mode, so any slot can serve as a counter (program counter, memory address register).

It sits directly on the bus alongside the ALU and RAM and is sequenced by the control unit.

## Interface
Parameters:
- WIDTH, 8, register and bus width in bits (≥ 2)
- NUM_REGS, 4, number of registers (≥ 2); SELW = max(1, $clog2(NUM_REGS))

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- bus  inout  WIDTH  shared tri-state bus
- ld_en  in  1  load bus value into register ld_sel
- ld_sel  in  SELW  load target index
- oe  in  1  drive register oe_sel onto bus
- oe_sel  in  SELW  output source index
- inc_en  in  1  increment register inc_sel by 1 (mod 2^WIDTH)
- inc_sel  in  SELW  increment target index
- clr  in  NUM_REGS  per-register synchronous clear, bit i clears register i
- err  out  1  sticky error: illegal index used
- flags  out  2  {zero, carry} of last increment (see Configuration)

## Operation
- **Storage.** Register array r[0..NUM_REGS-1], all 0 after reset.
- **Bus drive.** bus = r[oe_sel] when oe=1 and oe_sel < NUM_REGS, else all-Z. The drive is combinational, so the value is valid in the same cycle oe is asserted.
- **Per-register priority at the clock edge:** clr[i] > load > increment.
  - Load: r[ld_sel] <= bus.
  - Increment: r[inc_sel] <= r[inc_sel] + 1, wrapping from 2^WIDTH-1 to 0.
  - Only the winning operation on a given register takes effect.
- **Different targets.** Load and increment aimed at different indices both take effect in the same cycle.
- **oe and ld_en on the same index.** The register drives its own old value and reloads it, leaving the value unchanged. This case is legal and does not set err.
- **oe and ld_en on different indices.** Register-to-register transfer completes in one cycle.
- **Illegal index.** ld_sel, oe_sel or inc_sel ≥ NUM_REGS while the matching enable is high:
  - the operation is ignored;
  - the bus stays Z for an illegal oe_sel;
  - err is set and stays 1 until reset.
- **Load with no bus driver.** ld_en with oe=0 captures whatever the external driver places on the bus. If nothing drives it, the captured value is X; the control unit must never issue this.

## Timing
- Load, increment and clear: one-cycle latency; the new value is visible on the bus the cycle after the edge when oe selects that register.
- Bus drive latency: 0 cycles (combinational from oe and oe_sel).
- err: set on the edge where the illegal access is sampled; visible the following cycle.
- reset=0: immediately forces r[*]=0, err=0, flags=00 and bus to Z, independent of clk. Deasserting reset mid-sequence resumes normal operation on the next rising edge.
- Reset values of all outputs: bus Z, err 0, flags 00.

## Configuration
- **BUS_REG_BANK_FLAGS_EN defined:**
  - On every edge where an increment takes effect, flags.carry = 1 if the register wrapped from all-ones to 0, and flags.zero = 1 if the result is 0.
  - flags hold their value otherwise.
  - Clear and load do not touch flags.
- **BUS_REG_BANK_FLAGS_EN undefined:** flags is tied to 2'b00 and no flag logic is generated.

## Structure
- Package bus_reg_bank_pkg holds:
  - default WIDTH and NUM_REGS constants;
  - the SELW helper function;
  - the flag bit-index constants FLAG_ZERO = 0 and FLAG_CARRY = 1.
- Sub-module bus_reg_cell implements one register with clr/load/inc priority and its wrap output. The bank generates NUM_REGS instances, plus the index decode, the tri-state mux and the err/flags logic.

## Test plan
- Reset, then drive bus=8'hAA with ld_en=1, ld_sel=2 -> next cycle oe=1, oe_sel=2 puts 8'hAA on bus; r0, r1 and r3 read 0.
- r1=8'hFF, inc_en=1, inc_sel=1 -> r1=8'h00; with FLAGS_EN, flags={zero=1, carry=1}.
- r0=8'h3C, oe=1, oe_sel=0, ld_en=1, ld_sel=3 in one cycle -> r3=8'h3C, r0 unchanged, err=0.
- clr=4'b0010 with ld_en=1, ld_sel=1 and bus=8'h55 in the same cycle -> r1=0 (clear wins).
- NUM_REGS=3: oe=1, oe_sel=3 -> bus stays Z, err=1 next cycle and stays 1; then reset=0 asserted mid-cycle -> err=0 and all registers 0 immediately.
- WIDTH=16, NUM_REGS=8: load 16'hBEEF into r7 and increment it -> reads 16'hBEF0.

Source files
------------

// File: rtl/bus_reg_bank_pkg.sv
// Shared constants and helpers for the bus register bank.
// Default geometry, select-width helper and flag bit positions.
package bus_reg_bank_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_NUM_REGS = 4;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;

  // Index width for a bank of n registers; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_reg_bank_if.sv
// Control/status bundle between the control unit (master) and the register bank (slave).
// The tri-state data bus itself stays a plain inout on the bank, shared with ALU and RAM.
interface bus_reg_bank_if
  import bus_reg_bank_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS
);
  localparam int SELW = sel_width(NUM_REGS);

  logic                ld_en;
  logic [SELW-1:0]     ld_sel;
  logic                oe;
  logic [SELW-1:0]     oe_sel;
  logic                inc_en;
  logic [SELW-1:0]     inc_sel;
  logic [NUM_REGS-1:0] clr;
  logic                err;
  logic [1:0]          flags;

  modport master (
    output ld_en, ld_sel, oe, oe_sel, inc_en, inc_sel, clr,
    input  err, flags
  );

  modport slave (
    input  ld_en, ld_sel, oe, oe_sel, inc_en, inc_sel, clr,
    output err, flags
  );

endinterface

// File: rtl/bus_reg_bank_cell.sv
// One bank register: clear beats load beats increment, with increment wrap indication.
module bus_reg_cell #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             ld,
  input  logic             inc,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             inc_eff,
  output logic             wrap
);

  // Increment only counts when neither clear nor load claims the register.
  assign inc_eff = inc && !clr && !ld;
  assign wrap    = inc_eff && (&q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end else if (inc) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/bus_reg_bank.sv
// NUM_REGS x WIDTH general-purpose register bank on the shared tri-state system bus.
// Define BUS_REG_BANK_FLAGS_EN to generate zero/carry flags from increments; otherwise flags read 00.
module bus_reg_bank
  import bus_reg_bank_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [WIDTH-1:0] bus,
  bus_reg_bank_if.slave    ctl
);

  logic [NUM_REGS-1:0] ld_hit;
  logic [NUM_REGS-1:0] inc_hit;
  logic [NUM_REGS-1:0] inc_eff;
  logic [NUM_REGS-1:0] wrap;
  logic [WIDTH-1:0]    q [NUM_REGS];
  logic [WIDTH-1:0]    rd_val;
  logic                ld_bad;
  logic                oe_bad;
  logic                inc_bad;
  logic                oe_ok;
  logic                err_q;

  always_comb begin
    ld_hit  = '0;
    inc_hit = '0;
    rd_val  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      ld_hit[i]  = ctl.ld_en  && (int'(ctl.ld_sel)  == i);
      inc_hit[i] = ctl.inc_en && (int'(ctl.inc_sel) == i);
      if (int'(ctl.oe_sel) == i) begin
        rd_val = q[i];
      end
    end
  end

  assign ld_bad  = ctl.ld_en  && (int'(ctl.ld_sel)  >= NUM_REGS);
  assign oe_bad  = ctl.oe     && (int'(ctl.oe_sel)  >= NUM_REGS);
  assign inc_bad = ctl.inc_en && (int'(ctl.inc_sel) >= NUM_REGS);

  // The bank releases the bus while reset is held, even with oe asserted.
  assign oe_ok = reset && ctl.oe && !oe_bad;
  assign bus   = oe_ok ? rd_val : {WIDTH{1'bz}};

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
    bus_reg_cell #(
      .WIDTH(WIDTH)
    ) u_cell (
      .clk     (clk),
      .reset   (reset),
      .clr     (ctl.clr[g]),
      .ld      (ld_hit[g]),
      .inc     (inc_hit[g]),
      .d       (bus),
      .q       (q[g]),
      .inc_eff (inc_eff[g]),
      .wrap    (wrap[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (ld_bad || oe_bad || inc_bad) begin
      err_q <= 1'b1;
    end
  end

  assign ctl.err = err_q;

`ifdef BUS_REG_BANK_FLAGS_EN
  logic [1:0] flags_q;

  // An increment result is zero exactly when it wrapped, so both flags track wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= 2'b00;
    end else if (|inc_eff) begin
      flags_q[FLAG_ZERO]  <= |wrap;
      flags_q[FLAG_CARRY] <= |wrap;
    end
  end

  assign ctl.flags = flags_q;
`else
  logic unused_flag_src;
  assign unused_flag_src = ^{inc_eff, wrap};
  assign ctl.flags       = 2'b00;
`endif

endmodule

// File: tb/tb_bus_reg_bank.sv
// Bench for bus_reg_bank: directed plan steps on three geometries plus randomized traffic
// on the default bank against an array-based reference model.
module tb_bus_reg_bank;
  import bus_reg_bank_pkg::*;

`ifdef BUS_REG_BANK_FLAGS_EN
  localparam logic [1:0] FL_MASK = 2'b11;
`else
  localparam logic [1:0] FL_MASK = 2'b00;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  wire  [7:0]  bus0;
  logic [7:0]  drv0;
  logic        drv0_en;
  assign bus0 = drv0_en ? drv0 : 8'bz;

  wire  [7:0]  bus1;
  logic [7:0]  drv1;
  logic        drv1_en;
  assign bus1 = drv1_en ? drv1 : 8'bz;

  wire  [15:0] bus2;
  logic [15:0] drv2;
  logic        drv2_en;
  assign bus2 = drv2_en ? drv2 : 16'bz;

  bus_reg_bank_if #(.NUM_REGS(4)) if0 ();
  bus_reg_bank_if #(.NUM_REGS(3)) if1 ();
  bus_reg_bank_if #(.NUM_REGS(8)) if2 ();

  bus_reg_bank #(.WIDTH(8),  .NUM_REGS(4)) u0 (.clk(clk), .reset(reset), .bus(bus0), .ctl(if0));
  bus_reg_bank #(.WIDTH(8),  .NUM_REGS(3)) u1 (.clk(clk), .reset(reset), .bus(bus1), .ctl(if1));
  bus_reg_bank #(.WIDTH(16), .NUM_REGS(8)) u2 (.clk(clk), .reset(reset), .bus(bus2), .ctl(if2));

  // Reference model of the default bank.
  int         m0 [4];
  logic [1:0] mf0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    if0.ld_en = 1'b0; if0.oe = 1'b0; if0.inc_en = 1'b0; if0.clr = '0;
    if0.ld_sel = '0;  if0.oe_sel = '0; if0.inc_sel = '0;
    if1.ld_en = 1'b0; if1.oe = 1'b0; if1.inc_en = 1'b0; if1.clr = '0;
    if1.ld_sel = '0;  if1.oe_sel = '0; if1.inc_sel = '0;
    if2.ld_en = 1'b0; if2.oe = 1'b0; if2.inc_en = 1'b0; if2.clr = '0;
    if2.ld_sel = '0;  if2.oe_sel = '0; if2.inc_sel = '0;
    drv0_en = 1'b0; drv1_en = 1'b0; drv2_en = 1'b0;
    drv0 = '0; drv1 = '0; drv2 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_all();
  endtask

  // One cycle on the default bank: apply, check bus, clock, update model, check status.
  task automatic cyc0(input bit le, input int ls, input bit o, input int os, input bit ie,
                      input int isel, input logic [3:0] c, input logic [7:0] dv, input int exp_bus);
    int         nx [4];
    int         bv;
    logic [1:0] nf;
    @(negedge clk);
    if0.ld_en = le; if0.ld_sel = 2'(ls);
    if0.oe = o;     if0.oe_sel = 2'(os);
    if0.inc_en = ie; if0.inc_sel = 2'(isel);
    if0.clr = c;
    drv0 = dv; drv0_en = !o;
    #1;
    if (o) check("u0_bus_model", 32'(bus0), 32'(m0[os]));
    if (exp_bus >= 0) check("u0_bus_const", 32'(bus0), 32'(exp_bus));
    bv = o ? m0[os] : int'(dv);
    nf = mf0;
    for (int i = 0; i < 4; i++) begin
      nx[i] = m0[i];
      if (c[i]) nx[i] = 0;
      else if (le && ls == i) nx[i] = bv;
      else if (ie && isel == i) begin
        nx[i] = (m0[i] + 1) % 256;
        nf[FLAG_CARRY] = (m0[i] == 255);
        nf[FLAG_ZERO]  = (nx[i] == 0);
      end
    end
    tick();
    m0  = nx;
    mf0 = nf;
    check("u0_err", 32'(if0.err), 32'(0));
    check("u0_flags", 32'(if0.flags), 32'(mf0 & FL_MASK));
  endtask

  task automatic set1(input bit le, input int ls, input bit o, input int os, input bit ie,
                      input int isel, input logic [2:0] c, input logic [7:0] dv);
    @(negedge clk);
    if1.ld_en = le; if1.ld_sel = 2'(ls);
    if1.oe = o;     if1.oe_sel = 2'(os);
    if1.inc_en = ie; if1.inc_sel = 2'(isel);
    if1.clr = c;
    drv1 = dv; drv1_en = !o;
    #1;
  endtask

  task automatic rd1(input int sel, input logic [7:0] exp, input string tag);
    set1(1'b0, 0, 1'b1, sel, 1'b0, 0, 3'b000, 8'h00);
    check(tag, 32'(bus1), 32'(exp));
    tick();
  endtask

  task automatic set2(input bit le, input int ls, input bit o, input int os, input bit ie,
                      input int isel, input logic [7:0] c, input logic [15:0] dv);
    @(negedge clk);
    if2.ld_en = le; if2.ld_sel = 3'(ls);
    if2.oe = o;     if2.oe_sel = 3'(os);
    if2.inc_en = ie; if2.inc_sel = 3'(isel);
    if2.clr = c;
    drv2 = dv; drv2_en = !o;
    #1;
  endtask

  task automatic rd2(input int sel, input logic [15:0] exp, input string tag);
    set2(1'b0, 0, 1'b1, sel, 1'b0, 0, 8'h00, 16'h0000);
    check(tag, 32'(bus2), 32'(exp));
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    idle_all();
    for (int i = 0; i < 4; i++) m0[i] = 0;
    mf0 = 2'b00;
    #2 reset = 1'b0;
    #1;
    check("rst_err0", 32'(if0.err), 32'(0));
    check("rst_flags0", 32'(if0.flags), 32'(0));
    check("rst_err1", 32'(if1.err), 32'(0));
    @(negedge clk);
    reset = 1'b1;

    // Load from the bus, then read back; untouched registers stay zero.
    cyc0(1, 2, 0, 0, 0, 0, 4'b0000, 8'hAA, -1);
    cyc0(0, 0, 1, 2, 0, 0, 4'b0000, 8'h00, 32'hAA);
    cyc0(0, 0, 1, 0, 0, 0, 4'b0000, 8'h00, 0);
    cyc0(0, 0, 1, 1, 0, 0, 4'b0000, 8'h00, 0);
    cyc0(0, 0, 1, 3, 0, 0, 4'b0000, 8'h00, 0);

    // Increment wraps all-ones to zero.
    cyc0(1, 1, 0, 0, 0, 0, 4'b0000, 8'hFF, -1);
    cyc0(0, 0, 0, 0, 1, 1, 4'b0000, 8'h00, -1);
    check("wrap_flags", 32'(if0.flags), 32'(2'b11 & FL_MASK));
    cyc0(0, 0, 1, 1, 0, 0, 4'b0000, 8'h00, 0);

    // One-cycle register-to-register transfer.
    cyc0(1, 0, 0, 0, 0, 0, 4'b0000, 8'h3C, -1);
    cyc0(1, 3, 1, 0, 0, 0, 4'b0000, 8'h00, 32'h3C);
    cyc0(0, 0, 1, 3, 0, 0, 4'b0000, 8'h00, 32'h3C);
    cyc0(0, 0, 1, 0, 0, 0, 4'b0000, 8'h00, 32'h3C);

    // Same-index oe+load keeps the value.
    cyc0(1, 0, 1, 0, 0, 0, 4'b0000, 8'h00, 32'h3C);
    cyc0(0, 0, 1, 0, 0, 0, 4'b0000, 8'h00, 32'h3C);

    // Clear beats a simultaneous load.
    cyc0(1, 1, 0, 0, 0, 0, 4'b0010, 8'h55, -1);
    cyc0(0, 0, 1, 1, 0, 0, 4'b0000, 8'h00, 0);

    // Three-register bank: illegal indices.
    set1(1, 0, 0, 0, 0, 0, 3'b000, 8'h11); tick();
    set1(1, 1, 0, 0, 0, 0, 3'b000, 8'h22); tick();
    set1(1, 2, 0, 0, 0, 0, 3'b000, 8'h33); tick();
    check("u1_err_clean", 32'(if1.err), 32'(0));
    set1(0, 0, 1, 3, 0, 0, 3'b000, 8'h00);
    drv1_en = 1'b1;
    drv1    = 8'h00;
    #1;
    check("u1_oe_illegal_released", 32'(bus1), 32'(0));
    tick();
    check("u1_err_set", 32'(if1.err), 32'(1));
    set1(1, 3, 0, 0, 0, 0, 3'b000, 8'h77); tick();
    set1(0, 0, 0, 0, 1, 3, 3'b000, 8'h00); tick();
    rd1(0, 8'h11, "u1_r0_kept");
    rd1(1, 8'h22, "u1_r1_kept");
    rd1(2, 8'h33, "u1_r2_kept");
    check("u1_err_sticky", 32'(if1.err), 32'(1));

    // Wide bank.
    set2(1, 7, 0, 0, 0, 0, 8'h00, 16'hBEEF); tick();
    set2(0, 0, 0, 0, 1, 7, 8'h00, 16'h0000); tick();
    rd2(7, 16'hBEF0, "u2_r7_inc");
    rd2(0, 16'h0000, "u2_r0_zero");
    set2(1, 3, 0, 0, 0, 0, 8'h00, 16'hFFFF); tick();
    set2(0, 0, 0, 0, 1, 3, 8'h00, 16'h0000); tick();
    rd2(3, 16'h0000, "u2_r3_wrap");
    check("u2_err", 32'(if2.err), 32'(0));

    // Randomized traffic on the default bank.
    for (int k = 0; k < 300; k++) begin
      cyc0(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           4'($urandom & $urandom), 8'($urandom), -1);
    end
    for (int i = 0; i < 4; i++) cyc0(0, 0, 1, i, 0, 0, 4'b0000, 8'h00, -1);

    // Asynchronous reset pulse between clock edges.
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_err1", 32'(if1.err), 32'(0));
    check("async_flags0", 32'(if0.flags), 32'(0));
    for (int i = 0; i < 4; i++) m0[i] = 0;
    mf0 = 2'b00;
    #1 reset = 1'b1;
    rd1(0, 8'h00, "async_u1_r0");
    rd1(1, 8'h00, "async_u1_r1");
    rd1(2, 8'h00, "async_u1_r2");
    rd2(7, 16'h0000, "async_u2_r7");
    for (int i = 0; i < 4; i++) cyc0(0, 0, 1, i, 0, 0, 4'b0000, 8'h00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
